// File: rtl/signal_phase_arbiter.sv
// signal_phase_arbiter: round-robin actuated traffic-signal controller with min/max green, yellow and all-red timing.
// Define SIGNAL_PREEMPT_EN to add the preempt/preempt_dir emergency-vehicle override.
module signal_phase_arbiter #(
  parameter int NUM_DIR   = 2,
  parameter int MIN_GREEN = 3,
  parameter int MAX_GREEN = 6,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic [NUM_DIR-1:0]         req,
`ifdef SIGNAL_PREEMPT_EN
  input  logic                       preempt,
  input  logic [$clog2(NUM_DIR)-1:0] preempt_dir,
`endif
  output logic [NUM_DIR-1:0]         grant,
  output logic [3*NUM_DIR-1:0]       lit,
  output logic [$clog2(NUM_DIR)-1:0] cur_dir,
  output logic [NUM_DIR-1:0]         pending
);
  localparam int DW = $clog2(NUM_DIR);
  typedef enum logic [1:0] {ALLRED, GREEN, YELLOW} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n;
  logic [DW-1:0] cur_dir_q, cur_dir_d, rr_dir, pre_tgt;
  logic [NUM_DIR-1:0] pending_q, pending_d, grant_q, grant_d, others;
  logic [3*NUM_DIR-1:0] lit_q, lit_d;
  logic other_req, gap_out, max_out, go_green, go_yellow, go_red;
  logic pre_hold, pre_kick, pre_sel;
`ifdef SIGNAL_PREEMPT_EN
  logic pre_q, pre_d;
  logic [DW-1:0] pre_dir_q, pre_dir_d;
  // The preempt target is remembered so the next green honours it even if preempt drops during clearance.
  always_comb begin
    pre_hold  = preempt && preempt_dir == cur_dir_q;
    pre_kick  = preempt;
    pre_sel   = preempt | pre_q;
    pre_tgt   = preempt ? preempt_dir : pre_dir_q;
    pre_d     = (preempt && !pre_hold) || (pre_q && state_q != GREEN);
    pre_dir_d = preempt ? preempt_dir : pre_dir_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pre_q     <= 1'b0;
      pre_dir_q <= '0;
    end else begin
      pre_q     <= pre_d;
      pre_dir_q <= pre_dir_d;
    end
`else
  assign pre_hold = 1'b0;
  assign pre_kick = 1'b0;
  assign pre_sel  = 1'b0;
  assign pre_tgt  = '0;
`endif
  always_comb begin
    cnt_n = (cnt_q >= CNT_W'(MAX_GREEN)) ? cnt_q : cnt_q + 1'b1;
    others = pending_q;
    others[cur_dir_q] = 1'b0;
    other_req = |others;
    // Scan downward so the nearest pending direction after cur_dir wins.
    rr_dir = cur_dir_q;
    for (int k = NUM_DIR; k >= 1; k--) begin
      if (pending_q[(int'(cur_dir_q) + k) % NUM_DIR]) rr_dir = DW'((int'(cur_dir_q) + k) % NUM_DIR);
    end
    gap_out   = cnt_n >= CNT_W'(MIN_GREEN) && other_req && !req[cur_dir_q];
    max_out   = cnt_n >= CNT_W'(MAX_GREEN) && other_req;
    go_green  = tick && state_q == ALLRED && cnt_n == CNT_W'(ALLRED_T);
    go_yellow = tick && state_q == GREEN && !pre_hold && (pre_kick || gap_out || max_out);
    go_red    = tick && state_q == YELLOW && cnt_n == CNT_W'(YELLOW_T);
    state_d   = go_green ? GREEN : go_yellow ? YELLOW : go_red ? ALLRED : state_q;
    cnt_d     = (go_green || go_yellow || go_red) ? '0 : tick ? cnt_n : cnt_q;
    cur_dir_d = go_green ? (pre_sel ? pre_tgt : rr_dir) : cur_dir_q;
    pending_d = pending_q | req;
    if (go_green) pending_d[cur_dir_d] = 1'b0;
    for (int i = 0; i < NUM_DIR; i++) begin
      grant_d[i]      = state_d != ALLRED && cur_dir_d == DW'(i);
      lit_d[3*i +: 3] = grant_d[i] ? (state_d == GREEN ? 3'b001 : 3'b010) : 3'b100;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= ALLRED;
      cnt_q     <= '0;
      cur_dir_q <= '0;
      pending_q <= '0;
      grant_q   <= '0;
      lit_q     <= {NUM_DIR{3'b100}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_dir_q <= cur_dir_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      lit_q     <= lit_d;
    end
  assign grant   = grant_q;
  assign lit     = lit_q;
  assign cur_dir = cur_dir_q;
  assign pending = pending_q;
endmodule

// File: tb/tb_signal_phase_arbiter.sv
// tb_signal_phase_arbiter: directed vector table, reset-in-yellow and randomized checks of signal_phase_arbiter (NUM_DIR=4).
module tb_signal_phase_arbiter;
  localparam int N = 4, MING = 3, MAXG = 6, YT = 2, ART = 1;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0;
  logic [N-1:0] req = '0, grant, pending;
  logic [3*N-1:0] lit;
  logic [1:0] cur_dir;
`ifdef SIGNAL_PREEMPT_EN
  logic preempt = 1'b0;
  logic [1:0] preempt_dir = '0;
`endif
  signal_phase_arbiter #(.NUM_DIR(N)) dut (
    .clk(clk), .reset(reset), .tick(tick), .req(req),
`ifdef SIGNAL_PREEMPT_EN
    .preempt(preempt), .preempt_dir(preempt_dir),
`endif
    .grant(grant), .lit(lit), .cur_dir(cur_dir), .pending(pending)
  );
  always #5 clk = ~clk;
  typedef struct {logic [N-1:0] req; int reps; int ph; int dir; logic [N-1:0] pend;} vec_t;
  vec_t tv[$];
  int n_vec = 0, n_bad = 0;
  bit use_model = 1'b1;
  int m_ph, m_dir, m_el;
  bit [N-1:0] m_pend;
  task automatic m_reset();
    m_ph = 0; m_dir = 0; m_el = 0; m_pend = '0;
  endtask
  // Phases: 0 all-red, 1 green, 2 yellow; m_el counts ticks since phase entry without saturation.
  task automatic m_step(input bit [N-1:0] r, input bit t);
    bit [N-1:0] np;
    bit others;
    int nd;
    np = m_pend | r;
    if (t) begin
      m_el++;
      others = 1'b0;
      for (int j = 0; j < N; j++) if (j != m_dir && m_pend[j]) others = 1'b1;
      if (m_ph == 0 && m_el == ART) begin
        nd = m_dir;
        for (int k = 1; k <= N; k++) if (m_pend[(m_dir + k) % N]) begin nd = (m_dir + k) % N; break; end
        m_dir = nd; np[nd] = 1'b0; m_ph = 1; m_el = 0;
      end else if (m_ph == 1 && others && ((m_el >= MING && !r[m_dir]) || m_el >= MAXG)) begin
        m_ph = 2; m_el = 0;
      end else if (m_ph == 2 && m_el == YT) begin
        m_ph = 0; m_el = 0;
      end
    end
    m_pend = np;
  endtask
  function automatic logic [3*N-1:0] lit_of(int ph, int d);
    for (int i = 0; i < N; i++) lit_of[3*i +: 3] = (ph != 0 && i == d) ? (ph == 1 ? 3'b001 : 3'b010) : 3'b100;
  endfunction
  function automatic logic [N-1:0] grant_of(int ph, int d);
    for (int i = 0; i < N; i++) grant_of[i] = ph != 0 && i == d;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic check_vs(input string nm, input int ph, input int d, input logic [N-1:0] p);
    chk({nm, ".lit"}, 32'(lit), 32'(lit_of(ph, d)));
    chk({nm, ".grant"}, 32'(grant), 32'(grant_of(ph, d)));
    chk({nm, ".cur_dir"}, 32'(cur_dir), 32'(d));
    chk({nm, ".pending"}, 32'(pending), 32'(p));
  endtask
  task automatic safety();
    int greens;
    greens = 0;
    for (int i = 0; i < N; i++) greens += int'(lit[3*i]);
    assert ($onehot0(grant)) else begin n_bad++; $display("FAIL grant_onehot: got %b", grant); end
    assert (greens <= 1) else begin n_bad++; $display("FAIL single_green: got lit %b", lit); end
  endtask
  task automatic apply(input logic [N-1:0] r, input bit t);
    req = r; tick = t;
    m_step(r, t);
    @(negedge clk);
    safety();
    if (use_model) check_vs("model", m_ph, m_dir, m_pend);
  endtask
  initial begin
    tv.push_back('{4'b0000, 1, 1, 0, 4'b0000});
    tv.push_back('{4'b0010, 1, 1, 0, 4'b0010});
    tv.push_back('{4'b0000, 1, 1, 0, 4'b0010});
    tv.push_back('{4'b0000, 2, 2, 0, 4'b0010});
    tv.push_back('{4'b0000, 1, 0, 0, 4'b0010});
    tv.push_back('{4'b0000, 1, 1, 1, 4'b0000});
    tv.push_back('{4'b0110, 1, 1, 1, 4'b0110});
    tv.push_back('{4'b0010, 4, 1, 1, 4'b0110});
    tv.push_back('{4'b0010, 1, 2, 1, 4'b0110});
    tv.push_back('{4'b0000, 1, 2, 1, 4'b0110});
    tv.push_back('{4'b0000, 1, 0, 1, 4'b0110});
    tv.push_back('{4'b0000, 1, 1, 2, 4'b0010});
    tv.push_back('{4'b0000, 2, 1, 2, 4'b0010});
    tv.push_back('{4'b0000, 2, 2, 2, 4'b0010});
    tv.push_back('{4'b0000, 1, 0, 2, 4'b0010});
    tv.push_back('{4'b0000, 1, 1, 1, 4'b0000});
    tv.push_back('{4'b1001, 1, 1, 1, 4'b1001});
    tv.push_back('{4'b0000, 1, 1, 1, 4'b1001});
    tv.push_back('{4'b0000, 2, 2, 1, 4'b1001});
    tv.push_back('{4'b0000, 1, 0, 1, 4'b1001});
    tv.push_back('{4'b0000, 1, 1, 3, 4'b0001});
    tv.push_back('{4'b0000, 2, 1, 3, 4'b0001});
    tv.push_back('{4'b0000, 2, 2, 3, 4'b0001});
    tv.push_back('{4'b0000, 1, 0, 3, 4'b0001});
    tv.push_back('{4'b0000, 1, 1, 0, 4'b0000});
    tv.push_back('{4'b0000, 20, 1, 0, 4'b0000});
    m_reset();
    repeat (2) @(negedge clk);
    check_vs("reset", 0, 0, 4'b0000);
    reset = 1'b0;
    foreach (tv[v]) for (int r = 0; r < tv[v].reps; r++) begin
      apply(tv[v].req, 1'b1);
      check_vs($sformatf("vec%0d", v), tv[v].ph, tv[v].dir, tv[v].pend);
    end
    apply(4'b0100, 1'b1);
    apply(4'b0000, 1'b1);
    check_vs("to_yellow", 2, 0, 4'b0100);
    #2 reset = 1'b1;
    #1 check_vs("rst_in_yellow", 0, 0, 4'b0000);
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    apply(4'b0000, 1'b1);
    check_vs("post_reset", 1, 0, 4'b0000);
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = $urandom_range(0, 7) == 0;
      apply(r, $urandom_range(0, 3) != 0);
    end
`ifdef SIGNAL_PREEMPT_EN
    use_model = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    apply(4'b0000, 1'b1);
    check_vs("pre_g0", 1, 0, 4'b0000);
    preempt = 1'b1; preempt_dir = 2'd1;
    apply(4'b0000, 1'b1);
    check_vs("pre_y0", 2, 0, 4'b0000);
    apply(4'b0000, 1'b1);
    apply(4'b0101, 1'b1);
    check_vs("pre_red", 0, 0, 4'b0101);
    apply(4'b0000, 1'b1);
    check_vs("pre_g1", 1, 1, 4'b0101);
    repeat (8) apply(4'b0000, 1'b1);
    check_vs("pre_hold", 1, 1, 4'b0101);
    preempt = 1'b0;
    apply(4'b0000, 1'b1);
    check_vs("pre_release", 2, 1, 4'b0101);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/signal_phase_arbiter.md
Name: signal_phase_arbiter

Overview:
- Actuated traffic-signal controller. Shares one intersection (the resource) among NUM_DIR approach directions (the requesters) using round-robin arbitration.
- Enforces minimum green, maximum green, yellow and all-red clearance times, counted in prescaler ticks.
- Sits between the debounced button/sensor inputs and the LED outputs. It replaces the fixed two-direction signal FSM when more approaches or timed phases are needed.

Parameters:
- NUM_DIR, 2, number of approach directions (2..8).
- MIN_GREEN, 3, minimum green duration in ticks (>=1).
- MAX_GREEN, 6, maximum green in ticks while another direction is waiting (>=MIN_GREEN).
- YELLOW_T, 2, yellow duration in ticks (>=1).
- ALLRED_T, 1, all-red clearance in ticks (>=1).
- CNT_W, 8, width of the tick counter; must hold MAX_GREEN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- tick  in  1  one-clk enable pulse from the prescaler; all timing advances only on tick.
- req  in  NUM_DIR  per-direction demand (sensor or debounced button), level or pulse.
- grant  out  NUM_DIR  one-hot, registered; bit i high while direction i is green or yellow.
- lit  out  3*NUM_DIR  lit[3i+2:3i] = {red, yellow, green}, active-high, registered.
- cur_dir  out  $clog2(NUM_DIR)  index of the direction that holds or last held right-of-way.
- pending  out  NUM_DIR  latched, not-yet-served requests.

Behaviour:
- Reset values: state ALLRED, cnt 0, cur_dir 0, pending 0, grant 0, every lit field 3'b100.
- States:
  - ALLRED: all lit fields red.
  - GREEN: cur_dir lit 3'b001, all others red.
  - YELLOW: cur_dir lit 3'b010, all others red.
- Counter: cnt clears on every state entry. On each tick, cnt_n = cnt+1, saturating at MAX_GREEN. No state change ever occurs on a cycle without tick.
- Pending: pending[i] is set on any clk where req[i]=1. It clears on the clk where direction i enters GREEN; a simultaneous req[i] on that clk does not re-set it.
- other_req = OR of pending[j] for all j != cur_dir.
- ALLRED -> GREEN on a tick with cnt_n == ALLRED_T.
  - New cur_dir = first j with pending[j]=1, searching cur_dir+1, cur_dir+2, ... with wrap-around modulo NUM_DIR.
  - If no direction is pending, cur_dir is unchanged and is re-granted (rest-in-green).
- GREEN -> YELLOW on a tick when either condition holds:
  - gap-out: cnt_n >= MIN_GREEN, other_req=1 and req[cur_dir]=0;
  - max-out: cnt_n >= MAX_GREEN and other_req=1.
- GREEN with other_req=0 holds indefinitely; cnt saturates at MAX_GREEN.
- YELLOW -> ALLRED on a tick with cnt_n == YELLOW_T.
- All outputs are registered. lit, grant and cur_dir change on the same clk edge as the state. Latency from the deciding tick to the visible change is 1 clk.
- When req for two directions arrives on the same clk, round-robin order from cur_dir+1 decides; the loser remains pending.
- Asynchronous reset mid-phase (including during YELLOW) forces the reset values immediately. No yellow is shown on reset.
- grant is always one-hot or zero and lit is never green for two directions. A violation of either is a design error; the bench asserts both.

Optional Feature:
- Macro: SIGNAL_PREEMPT_EN.
- Defined:
  - Adds ports preempt (in, 1) and preempt_dir (in, $clog2(NUM_DIR)).
  - While preempt=1 and cur_dir != preempt_dir, GREEN -> YELLOW on the next tick, ignoring MIN_GREEN.
  - The following ALLRED -> GREEN selects preempt_dir regardless of round-robin order.
  - While preempt=1 and preempt_dir is green, no exit from GREEN occurs.
  - pending bits are preserved across the preemption.
- Undefined: the ports are absent and behaviour is exactly as above.

Test Plan:
All cases use defaults, tick=1 every clk.
- Reset, no req: ALLRED for 1 tick, then dir0 GREEN (lit=6'b100_001 for NUM_DIR=2) held for 20 ticks; grant=2'b01 throughout.
- dir0 green, pulse req[1] at cnt=0, req[0]=0: yellow after tick 3 (gap-out), red after 2 more ticks, ALLRED 1 tick, then dir1 GREEN; pending[1] clears.
- dir0 green with req[0] held 1, pulse req[1]: dir0 stays green through tick 5 and goes yellow on tick 6 (max-out).
- NUM_DIR=4, cur_dir=1, req[0] and req[3] pulsed together: next green is dir3, then dir0; each served exactly once.
- Assert reset during YELLOW: lit all 3'b100 in the same cycle, cnt=0; after 1 tick dir0 green.
- SIGNAL_PREEMPT_EN, dir0 green at cnt=0, preempt=1 with preempt_dir=1: yellow next tick, dir1 green 4 ticks later, held while preempt=1.
